reg_serial_paralelo: RTL and testbench

Serial-in / parallel-out receiver. It is the far end of the team's parallel-to-serial shift register link. It collects NBITS_DATA bits sent LSB-first on a one-bit line, qualified by a bit strobe and a start-of-frame marker, and presents each completed word on a parallel port. The word is held with a valid/ack handshake, and the block flags overrun and framing errors.

---
 rtl/reg_serial_pkg.sv | 18 +
 rtl/shift_in_reg.sv | 36 +++
 rtl/reg_serial_paralelo.sv | 104 ++++++++++
 tb/tb_reg_serial_paralelo.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/reg_serial_pkg.sv
// Shared types and constants for the serial-in / parallel-out receiver.
//   rx_state_t      : receiver FSM state (IDLE, RECV)
//   NBITS_DATA_DEF  : default word width
//   cnt_width()     : bit-counter width able to hold 0..nbits
package reg_serial_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } rx_state_t;

  localparam int unsigned NBITS_DATA_DEF = 4;

  function automatic int unsigned cnt_width(input int unsigned nbits);
    return $clog2(nbits + 1);
  endfunction

endpackage

// File: rtl/shift_in_reg.sv
// Serial-in, right-shift register; new bits enter at the MSB so the first
// bit of a frame ends up in bit 0 after NBITS_DATA shifts.
//   clk, reset : clock, async active-high reset
//   clear      : zero the register and shift in serial_in (frame start)
//   shift_en   : shift serial_in in at the MSB
//   serial_in  : serial data bit
//   q          : register contents
module shift_in_reg
  import reg_serial_pkg::*;
#(
  parameter int unsigned NBITS_DATA = NBITS_DATA_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  shift_en,
  input  logic                  serial_in,
  output logic [NBITS_DATA-1:0] q
);

  logic [NBITS_DATA-1:0] msb_bit;

  // serial_in positioned at the MSB; shift form also covers NBITS_DATA=1
  assign msb_bit = NBITS_DATA'(serial_in) << (NBITS_DATA - 1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (clear) begin
      q <= msb_bit;
    end else if (shift_en) begin
      q <= (q >> 1) | msb_bit;
    end
  end

endmodule

// File: rtl/reg_serial_paralelo.sv
// Serial-in / parallel-out receiver with valid/ack output handshake.
// Collects NBITS_DATA bits LSB-first (sof marks bit 0), presents the word
// on data_out, and flags dropped words (overrun) and aborted frames
// (frame_err).
//   clk, reset : clock, async active-high reset
//   serial_in  : serial data, sampled when bit_en=1
//   bit_en     : bit strobe
//   sof        : start of frame, qualified by bit_en
//   data_ack   : consumer accepts data_out
//   data_out   : last completed word
//   data_valid : data_out holds an unacknowledged word
//   busy       : frame in progress
//   overrun    : sticky, a completed word was dropped
//   frame_err  : one-cycle pulse, frame aborted by a new sof
module reg_serial_paralelo
  import reg_serial_pkg::*;
#(
  parameter int unsigned NBITS_DATA = NBITS_DATA_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  serial_in,
  input  logic                  bit_en,
  input  logic                  sof,
  input  logic                  data_ack,
  output logic [NBITS_DATA-1:0] data_out,
  output logic                  data_valid,
  output logic                  busy,
  output logic                  overrun,
  output logic                  frame_err
);

  localparam int unsigned CW = cnt_width(NBITS_DATA);

  rx_state_t             state;
  logic [CW-1:0]         count;
  logic [CW-1:0]         next_count_c;
  logic [NBITS_DATA-1:0] shreg;
  logic [NBITS_DATA-1:0] word_c;
  logic                  accept_c;
  logic                  complete_c;

  // A bit is taken on any sof, or on any strobe while a frame is open
  assign accept_c     = bit_en && (sof || (state == RECV));
  assign next_count_c = sof ? CW'(1) : (count + CW'(1));
  assign complete_c   = accept_c && (next_count_c == CW'(NBITS_DATA));

  // Word as it will look after the current bit is shifted in
  assign word_c = (shreg >> 1) | (NBITS_DATA'(serial_in) << (NBITS_DATA - 1));

  shift_in_reg #(
    .NBITS_DATA(NBITS_DATA)
  ) u_shift (
    .clk      (clk),
    .reset    (reset),
    .clear    (bit_en && sof),
    .shift_en (accept_c),
    .serial_in(serial_in),
    .q        (shreg)
  );

  // Frame FSM, bit counter and output handshake
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      count      <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      frame_err <= 1'b0;

      if (accept_c) begin
        if (sof && (state == RECV)) begin
          frame_err <= 1'b1;
        end
        if (complete_c) begin
          state <= IDLE;
          busy  <= 1'b0;
          count <= '0;
        end else begin
          state <= RECV;
          busy  <= 1'b1;
          count <= next_count_c;
        end
      end

      // A completion competing with an unacked word drops the new word
      if (complete_c) begin
        if (!data_valid || data_ack) begin
          data_out   <= word_c;
          data_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (data_ack) begin
        data_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_reg_serial_paralelo.sv
// Bench for reg_serial_paralelo (NBITS_DATA=4): directed frames followed by
// randomized traffic, every cycle compared against a frame-level model.
module tb_reg_serial_paralelo;

  localparam int unsigned N = 4;

  logic         clk;
  logic         reset;
  logic         serial_in;
  logic         bit_en;
  logic         sof;
  logic         data_ack;
  logic [N-1:0] data_out;
  logic         data_valid;
  logic         busy;
  logic         overrun;
  logic         frame_err;

  int errors = 0;
  int checks = 0;

  // Reference model state
  bit           m_in_frame;
  bit           m_bits[$];
  logic [N-1:0] m_out;
  bit           m_valid;
  bit           m_over;
  bit           m_ferr;
  int           ferr_count;

  reg_serial_paralelo #(.NBITS_DATA(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .serial_in (serial_in),
    .bit_en    (bit_en),
    .sof       (sof),
    .data_ack  (data_ack),
    .data_out  (data_out),
    .data_valid(data_valid),
    .busy      (busy),
    .overrun   (overrun),
    .frame_err (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_in_frame = 0;
    m_bits.delete();
    m_out   = '0;
    m_valid = 0;
    m_over  = 0;
    m_ferr  = 0;
  endtask

  // Frame-level behaviour: collect bits in a queue, build the word on the Nth
  task automatic model_step(input bit s, input bit be, input bit f, input bit ack);
    bit           done = 0;
    logic [N-1:0] w = '0;
    bit           ferr_n = 0;
    if (be) begin
      if (f) begin
        if (m_in_frame) ferr_n = 1;
        m_bits.delete();
        m_bits.push_back(s);
        m_in_frame = 1;
      end else if (m_in_frame) begin
        m_bits.push_back(s);
      end
      if (m_in_frame && m_bits.size() == N) begin
        for (int i = 0; i < N; i++) w[i] = m_bits[i];
        done = 1;
        m_in_frame = 0;
        m_bits.delete();
      end
    end
    if (done) begin
      if (!m_valid || ack) begin
        m_out   = w;
        m_valid = 1;
      end else begin
        m_over = 1;
      end
    end else if (ack) begin
      m_valid = 0;
    end
    m_ferr = ferr_n;
  endtask

  task automatic compare_all();
    check("data_out",   32'(data_out),   32'(m_out));
    check("data_valid", 32'(data_valid), 32'(m_valid));
    check("busy",       32'(busy),       32'(m_in_frame));
    check("overrun",    32'(overrun),    32'(m_over));
    check("frame_err",  32'(frame_err),  32'(m_ferr));
  endtask

  // One clock: drive at negedge, update model at posedge, sample 1ns later
  task automatic cycle(input bit s, input bit be, input bit f, input bit ack);
    @(negedge clk);
    serial_in = s;
    bit_en    = be;
    sof       = f;
    data_ack  = ack;
    @(posedge clk);
    model_step(s, be, f, ack);
    #1;
    if (frame_err) ferr_count++;
    compare_all();
  endtask

  task automatic send_frame(input logic [N-1:0] w, input bit ack_last);
    for (int i = 0; i < N; i++)
      cycle(w[i], 1'b1, i == 0, ack_last && (i == N - 1));
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    serial_in = 0; bit_en = 0; sof = 0; data_ack = 0;
    ferr_count = 0;
    reset = 1'b1;
    model_reset();
    #1;
    check("reset_valid", 32'(data_valid), 32'(0));
    check("reset_out",   32'(data_out),   32'(0));
    @(negedge clk); @(negedge clk);
    reset = 1'b0;

    // Bits 1,0,1,1 LSB-first -> 4'hD; busy during bits 2..4
    cycle(1, 1, 1, 0);
    check("busy_bit1", 32'(busy), 32'(1));
    cycle(0, 1, 0, 0);
    cycle(1, 1, 0, 0);
    check("busy_bit3", 32'(busy), 32'(1));
    cycle(1, 1, 0, 0);
    check("word_D", 32'(data_out), 32'('hD));
    check("busy_done", 32'(busy), 32'(0));

    // Hold unacked, then ack; word value persists
    idle_cycles(5);
    check("hold_valid", 32'(data_valid), 32'(1));
    cycle(0, 0, 0, 1);
    check("ack_clears", 32'(data_valid), 32'(0));
    check("ack_keeps_D", 32'(data_out), 32'('hD));

    // Ack with no word pending is ignored
    cycle(0, 0, 0, 1);

    // Bit strobe without sof in IDLE is ignored
    for (int i = 0; i < 3; i++) cycle(1, 1, 0, 0);
    check("idle_ignore", 32'(busy), 32'(0));

    // Unacked word + second frame -> overrun, old word kept
    send_frame(4'hD, 0);
    send_frame(4'h6, 0);
    check("overrun_set", 32'(overrun), 32'(1));
    check("overrun_keep", 32'(data_out), 32'('hD));

    // Ack coincident with last bit: new word taken, overrun unchanged
    send_frame(4'h4, 1);
    check("ack_last_word", 32'(data_out), 32'('h4));
    check("ack_last_valid", 32'(data_valid), 32'(1));

    // Asynchronous reset between edges with outputs active
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check("async_out",   32'(data_out),   32'(0));
    check("async_valid", 32'(data_valid), 32'(0));
    check("async_busy",  32'(busy),       32'(0));
    check("async_over",  32'(overrun),    32'(0));
    @(negedge clk);
    reset = 1'b0;

    // Resync: two bits, then sof with 1,1,1,1
    ferr_count = 0;
    cycle(0, 1, 1, 0);
    cycle(0, 1, 0, 0);
    cycle(1, 1, 1, 0);
    check("resync_busy", 32'(busy), 32'(1));
    cycle(1, 1, 0, 0);
    cycle(1, 1, 0, 0);
    cycle(1, 1, 0, 0);
    check("resync_word", 32'(data_out), 32'('hF));
    check("resync_ferr_once", 32'(ferr_count), 32'(1));

    // Gaps in bit_en hold a frame open
    cycle(0, 1, 1, 1);
    idle_cycles(3);
    cycle(1, 1, 0, 0);
    idle_cycles(2);
    cycle(1, 1, 0, 0);
    cycle(0, 1, 0, 0);
    check("gap_word", 32'(data_out), 32'('h6));

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      bit be, f, s, a;
      be = ($urandom_range(0, 3) != 0);
      f  = be && ($urandom_range(0, 5) == 0);
      s  = 1'($urandom);
      a  = ($urandom_range(0, 3) == 0);
      cycle(s, be, f, a);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
